// File: rtl/run_perf_unit_if.sv
// Run-control / event-statistics bus between the CPU top level and run_perf_unit.
// Master drives the control and event inputs; slave returns run, state and the readout.
interface run_perf_unit_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned SEL_W  = 3
);
   logic              halt_req;
   logic              go;
   logic              step;
   logic [NUM_CH-1:0] ev;
   logic              clr;
   logic              freeze;
   logic [SEL_W-1:0]  sel;
   logic              run;
   logic [1:0]        state;
   logic [CNT_W-1:0]  rd_data;
   logic [NUM_CH-1:0] ovf;

   modport master (
      output halt_req, go, step, ev, clr, freeze, sel,
      input  run, state, rd_data, ovf
   );

   modport slave (
      input  halt_req, go, step, ev, clr, freeze, sel,
      output run, state, rd_data, ovf
   );
endinterface

// File: rtl/run_perf_unit.sv
// CPU run control (RUN/HALTED/STEP) plus NUM_CH event counters with wrap or
// saturate overflow, sticky overflow flags, freeze, clear and a registered readout.
module run_perf_unit #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned SEL_W    = 3,
   parameter int unsigned SATURATE = 0
) (
   input logic             clk,
   input logic             rst,
   run_perf_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_HALTED = 2'b01,
      ST_STEP   = 2'b10,
      ST_BAD    = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic               go_q, step_q;
   logic               go_rise, step_rise;
   logic               run_c;
   logic [CNT_W-1:0]   cnt_all [NUM_CH];
   logic [NUM_CH-1:0]  ovf_all;
   logic [CNT_W-1:0]   rd_q, rd_d;

   assign go_rise   = bus.go & ~go_q;
   assign step_rise = bus.step & ~step_q;

   // Edge-detect history and FSM state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         go_q    <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         go_q    <= bus.go;
         step_q  <= bus.step;
      end
   end

   // Next state and combinational CPU enable; go beats step when both rise together
   always_comb begin
      state_d = state_q;
      run_c   = 1'b0;
      case (state_q)
         ST_RUN: begin
            run_c = ~bus.halt_req | bus.go;
            if (bus.halt_req && !bus.go) state_d = ST_HALTED;
         end
         ST_HALTED: begin
            if (go_rise)        state_d = ST_RUN;
            else if (step_rise) state_d = ST_STEP;
         end
         ST_STEP: begin
            run_c   = 1'b1;
            state_d = ST_HALTED;
         end
         default: state_d = ST_RUN;
      endcase
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             ovf;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
         end else if (bus.clr) begin
            cnt <= '0;
            ovf <= 1'b0;
         end else if (bus.freeze) begin
            cnt <= cnt;
         end else if (bus.ev[i]) begin
            if (&cnt) begin
               ovf <= 1'b1;
               if (SATURATE == 0) cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end

      assign cnt_all[i] = cnt;
      assign ovf_all[i] = ovf;
   end

   // Out-of-range selects fall through to zero
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.sel == SEL_W'(i)) rd_d = cnt_all[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_q <= '0;
      else      rd_q <= rd_d;
   end

   assign bus.run     = run_c;
   assign bus.state   = state_q;
   assign bus.rd_data = rd_q;
   assign bus.ovf     = ovf_all;

endmodule
